fwd_scoreboard: RTL

Parametrised forwarding and hazard scoreboard for the pipelined datapath. It tracks in-flight destination registers across NSTAGES post-decode stages (EX, MEM, SAD1..SADn) and answers the decode stage's two source-register queries with a forwarding select, forwarded data and a load-use/multi-cycle stall. It replaces the fixed EX/MEM/SAD1-3 rd/RegWrite comparison with depth-generic tracking and adds a per-instruction result-ready latency, flush and a stall counter.

---
 rtl/fwd_scoreboard_pkg.sv | 32 +++
 rtl/fwd_lookup.sv | 40 ++++
 rtl/fwd_scoreboard.sv | 104 ++++++++++
 3 files changed

// File: rtl/fwd_scoreboard_pkg.sv
// Shared types and constants for the forwarding/hazard scoreboard.
// Entry fields are sized for the widest supported configuration so one struct serves every build.
package fwd_scoreboard_pkg;

    localparam int unsigned SB_NSTAGES = 5;
    localparam int unsigned SB_AW      = 5;
    localparam int unsigned SB_DW      = 32;

    // Upper bounds on register-address and ready-stage widths held in an entry.
    localparam int unsigned RD_MAX_W   = 8;
    localparam int unsigned RDY_MAX_W  = 8;

    // Forwarding select value meaning "take the register file".
    localparam int unsigned FWD_RF     = 0;

    typedef struct packed {
        logic                 valid;
        logic [RD_MAX_W-1:0]  rd;
        logic                 regwrite;
        logic [RDY_MAX_W-1:0] ready_at;
    } sb_entry_t;

    // Out-of-range ready stages are folded onto the last tracked stage.
    function automatic logic [RDY_MAX_W-1:0] clamp_ready(input int unsigned ready_at,
                                                         input int unsigned nstages);
        if (ready_at >= nstages) begin
            return RDY_MAX_W'(nstages - 1);
        end
        return RDY_MAX_W'(ready_at);
    endfunction

endpackage

// File: rtl/fwd_lookup.sv
// Priority match of one decode source register against all in-flight entries.
// The youngest matching producer decides between forwarding and a hazard.
module fwd_lookup
    import fwd_scoreboard_pkg::*;
#(
    parameter int unsigned NSTAGES = SB_NSTAGES,
    parameter int unsigned AW      = SB_AW,
    parameter int unsigned DW      = SB_DW,
    parameter int unsigned SW      = $clog2(NSTAGES + 1)
) (
    input  sb_entry_t              entries_i [NSTAGES],
    input  logic [AW-1:0]          qry_i,
    input  logic [NSTAGES*DW-1:0]  stage_data_i,
    output logic [SW-1:0]          sel_o,
    output logic [DW-1:0]          data_o,
    output logic                   hazard_o
);

    logic found;

    always_comb begin
        sel_o    = SW'(FWD_RF);
        data_o   = '0;
        hazard_o = 1'b0;
        found    = 1'b0;
        for (int s = 0; s < int'(NSTAGES); s++) begin
            if (!found && entries_i[s].valid && entries_i[s].regwrite &&
                (entries_i[s].rd == RD_MAX_W'(qry_i)) && (qry_i != '0)) begin
                found = 1'b1;
                if (s >= int'(32'(entries_i[s].ready_at))) begin
                    sel_o  = SW'(s + 1);
                    data_o = stage_data_i[s*DW +: DW];
                end else begin
                    hazard_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Depth-generic forwarding and load-use/multi-cycle hazard scoreboard for the decode stage.
// Entries shift one stage per cycle unconditionally; decode issue is blocked while a hazard exists.
module fwd_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter int unsigned NSTAGES = SB_NSTAGES,
    parameter int unsigned AW      = SB_AW,
    parameter int unsigned DW      = SB_DW,
    parameter int unsigned LW      = $clog2(NSTAGES),
    parameter int unsigned SW      = $clog2(NSTAGES + 1)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  IssueValid,
    input  logic [AW-1:0]         IssueRd,
    input  logic                  IssueRegWrite,
    input  logic [LW-1:0]         IssueReadyAt,
    input  logic                  Flush,
    input  logic [AW-1:0]         QryRsA,
    input  logic [AW-1:0]         QryRsB,
    input  logic [NSTAGES*DW-1:0] StageData,
    output logic [SW-1:0]         FwdSelA,
    output logic [SW-1:0]         FwdSelB,
    output logic [DW-1:0]         FwdDataA,
    output logic [DW-1:0]         FwdDataB,
    output logic                  Stall,
    output logic [15:0]           StallCount
);

    sb_entry_t   entries_q [NSTAGES];
    sb_entry_t   entries_d [NSTAGES];
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        hazard_a, hazard_b;
    logic        issue_accept;

    fwd_lookup #(
        .NSTAGES (NSTAGES),
        .AW      (AW),
        .DW      (DW),
        .SW      (SW)
    ) u_lookup_a (
        .entries_i    (entries_q),
        .qry_i        (QryRsA),
        .stage_data_i (StageData),
        .sel_o        (FwdSelA),
        .data_o       (FwdDataA),
        .hazard_o     (hazard_a)
    );

    fwd_lookup #(
        .NSTAGES (NSTAGES),
        .AW      (AW),
        .DW      (DW),
        .SW      (SW)
    ) u_lookup_b (
        .entries_i    (entries_q),
        .qry_i        (QryRsB),
        .stage_data_i (StageData),
        .sel_o        (FwdSelB),
        .data_o       (FwdDataB),
        .hazard_o     (hazard_b)
    );

    // A hazard only matters when there is an instruction trying to leave decode.
    assign Stall        = IssueValid && (hazard_a || hazard_b);
    assign issue_accept = IssueValid && !Stall && !Flush;

    always_comb begin
        entries_d[0] = '0;
        if (issue_accept) begin
            entries_d[0].valid    = 1'b1;
            entries_d[0].rd       = RD_MAX_W'(IssueRd);
            entries_d[0].regwrite = IssueRegWrite;
            entries_d[0].ready_at = clamp_ready(32'(IssueReadyAt), NSTAGES);
        end
        for (int s = 1; s < int'(NSTAGES); s++) begin
            entries_d[s] = entries_q[s-1];
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (Stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int s = 0; s < int'(NSTAGES); s++) begin
                entries_q[s] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int s = 0; s < int'(NSTAGES); s++) begin
                entries_q[s] <= entries_d[s];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;

endmodule
